// File: rtl/turbo_codec_scheduler.sv
// Round-robin scheduler sharing one turbo encoder/decoder engine pair between an encode and a decode requester.
// Define TURBO_SCHED_STATS_EN to build the saturating stat_* completion/timeout counters.
module turbo_codec_scheduler #(
  parameter int unsigned BLOCK_LEN = 8,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enc_req,
  input  logic [BLOCK_LEN-1:0] enc_data,
  output logic                 enc_gnt,
  output logic                 enc_done,
  output logic [2:0]           enc_result,
  input  logic                 dec_req,
  input  logic [2:0]           dec_sym,
  output logic                 dec_gnt,
  output logic                 dec_done,
  output logic                 dec_result,
  output logic                 err_timeout,
  output logic                 busy,
  output logic                 eng_start,
  output logic                 eng_mode,
  output logic                 eng_data,
  output logic [2:0]           eng_sym,
  input  logic                 eng_valid,
  input  logic [2:0]           eng_enc_out,
  input  logic                 eng_dec_out,
  output logic [7:0]           stat_enc_cnt,
  output logic [7:0]           stat_dec_cnt,
  output logic [7:0]           stat_to_cnt
);

  localparam int unsigned FCW = $clog2(BLOCK_LEN + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, FEED, WAIT, DONE} state_t;

  state_t               state;
  logic                 last_enc;
  logic [BLOCK_LEN-1:0] enc_sr;
  logic [2:0]           sym_q;
  logic [FCW-1:0]       feed_cnt;
  logic [TCW-1:0]       to_cnt;
  logic [FCW-1:0]       feed_last;
  logic                 wait_ok;
  logic                 wait_to;

  // FEED holds one extra cycle so the WAIT state never sees a valid that overlaps eng_start
  assign feed_last = eng_mode ? FCW'(BLOCK_LEN) : FCW'(1);
  assign wait_ok   = (state == WAIT) && eng_valid;
  assign wait_to   = (state == WAIT) && !eng_valid && (to_cnt == TCW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_enc    <= 1'b0;
      enc_sr      <= '0;
      sym_q       <= '0;
      feed_cnt    <= '0;
      to_cnt      <= '0;
      enc_gnt     <= 1'b0;
      dec_gnt     <= 1'b0;
      enc_done    <= 1'b0;
      dec_done    <= 1'b0;
      enc_result  <= '0;
      dec_result  <= 1'b0;
      err_timeout <= 1'b0;
      busy        <= 1'b0;
      eng_start   <= 1'b0;
      eng_mode    <= 1'b0;
      eng_data    <= 1'b0;
      eng_sym     <= '0;
    end else begin
      enc_gnt     <= 1'b0;
      dec_gnt     <= 1'b0;
      enc_done    <= 1'b0;
      dec_done    <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          // encode wins unless decode is also pending and encode went last
          if (enc_req && (!dec_req || !last_enc)) begin
            enc_gnt  <= 1'b1;
            enc_sr   <= enc_data;
            eng_mode <= 1'b1;
            last_enc <= 1'b1;
            busy     <= 1'b1;
            feed_cnt <= '0;
            state    <= FEED;
          end else if (dec_req) begin
            dec_gnt  <= 1'b1;
            sym_q    <= dec_sym;
            eng_mode <= 1'b0;
            last_enc <= 1'b0;
            busy     <= 1'b1;
            feed_cnt <= '0;
            state    <= FEED;
          end
        end
        FEED: begin
          if (feed_cnt == feed_last) begin
            eng_start <= 1'b0;
            eng_data  <= 1'b0;
            eng_sym   <= '0;
            to_cnt    <= '0;
            state     <= WAIT;
          end else begin
            eng_start <= 1'b1;
            feed_cnt  <= feed_cnt + FCW'(1);
            if (eng_mode) begin
              eng_data <= enc_sr[0];
              enc_sr   <= enc_sr >> 1;
            end else begin
              eng_sym <= sym_q;
            end
          end
        end
        WAIT: begin
          if (wait_ok || wait_to) begin
            if (eng_mode) begin
              enc_done   <= 1'b1;
              enc_result <= wait_ok ? eng_enc_out : 3'b000;
            end else begin
              dec_done   <= 1'b1;
              dec_result <= wait_ok ? eng_dec_out : 1'b0;
            end
            err_timeout <= wait_to;
            state       <= DONE;
          end else begin
            to_cnt <= to_cnt + TCW'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TURBO_SCHED_STATS_EN
  // saturating counters, updated on the edge that produces the done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_enc_cnt <= '0;
      stat_dec_cnt <= '0;
      stat_to_cnt  <= '0;
    end else begin
      if (wait_ok && eng_mode && (stat_enc_cnt != 8'hFF))
        stat_enc_cnt <= stat_enc_cnt + 8'd1;
      if (wait_ok && !eng_mode && (stat_dec_cnt != 8'hFF))
        stat_dec_cnt <= stat_dec_cnt + 8'd1;
      if (wait_to && (stat_to_cnt != 8'hFF))
        stat_to_cnt <= stat_to_cnt + 8'd1;
    end
  end
`else
  assign stat_enc_cnt = 8'd0;
  assign stat_dec_cnt = 8'd0;
  assign stat_to_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_turbo_codec_scheduler.sv
// Directed bench for turbo_codec_scheduler with a one-cycle-latency engine model.
module tb_turbo_codec_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enc_req = 1'b0;
  logic [7:0] enc_data = 8'h00;
  logic       enc_gnt, enc_done;
  logic [2:0] enc_result;
  logic       dec_req = 1'b0;
  logic [2:0] dec_sym = 3'b000;
  logic       dec_gnt, dec_done, dec_result;
  logic       err_timeout, busy;
  logic       eng_start, eng_mode, eng_data;
  logic [2:0] eng_sym;
  logic       eng_valid;
  logic [2:0] eng_enc_out;
  logic       eng_dec_out;
  logic [7:0] stat_enc_cnt, stat_dec_cnt, stat_to_cnt;

  logic       model_en = 1'b1;
  logic       force_valid = 1'b0;
  logic [2:0] force_enc_out = 3'b000;
  logic       start_d = 1'b0;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  turbo_codec_scheduler #(.BLOCK_LEN(8), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .enc_req(enc_req), .enc_data(enc_data), .enc_gnt(enc_gnt),
    .enc_done(enc_done), .enc_result(enc_result),
    .dec_req(dec_req), .dec_sym(dec_sym), .dec_gnt(dec_gnt),
    .dec_done(dec_done), .dec_result(dec_result),
    .err_timeout(err_timeout), .busy(busy),
    .eng_start(eng_start), .eng_mode(eng_mode), .eng_data(eng_data), .eng_sym(eng_sym),
    .eng_valid(eng_valid), .eng_enc_out(eng_enc_out), .eng_dec_out(eng_dec_out),
    .stat_enc_cnt(stat_enc_cnt), .stat_dec_cnt(stat_dec_cnt), .stat_to_cnt(stat_to_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    start_d <= reset ? 1'b0 : eng_start;
  end

  // engine: valid in the cycle right after the last eng_start cycle
  assign eng_valid   = (model_en && start_d && !eng_start) || force_valid;
  assign eng_enc_out = force_valid ? force_enc_out : 3'b101;
  assign eng_dec_out = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output logic is_enc, output int t);
    logic found = 1'b0;
    is_enc = 1'b0;
    t = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (enc_gnt || dec_gnt) begin
        found = 1'b1;
        is_enc = enc_gnt;
        t = cyc;
      end
    end
    check("gnt_seen", 32'(found), 32'd1);
  endtask

  task automatic wait_done(input int limit, output int t);
    logic found = 1'b0;
    t = 0;
    for (int i = 0; i < limit && !found; i++) begin
      tick();
      if (enc_done || dec_done) begin
        found = 1'b1;
        t = cyc;
      end
    end
    check("done_seen", 32'(found), 32'd1);
  endtask

  logic       who;
  int         tg, td, tprev;
  logic [7:0] pat;
  logic       saw;

  initial begin
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gnt", 32'({enc_gnt, dec_gnt, enc_done, dec_done}), 32'd0);
    check("rst_eng", 32'({eng_start, eng_mode, eng_data, eng_sym}), 32'd0);
    check("rst_res", 32'({enc_result, dec_result, err_timeout}), 32'd0);
    check("rst_stat", 32'({stat_enc_cnt, stat_dec_cnt, stat_to_cnt}), 32'd0);
    reset = 1'b0;

    // encode 8'hA5
    enc_data = 8'hA5; enc_req = 1'b1;
    wait_gnt(who, tg);
    enc_req = 1'b0;
    check("enc_who", 32'(who), 32'd1);
    check("enc_mode", 32'(eng_mode), 32'd1);
    check("enc_busy", 32'(busy), 32'd1);
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("enc_start", 32'(eng_start), 32'd1);
      check("enc_bit", 32'(eng_data), 32'(pat[i]));
    end
    tick();
    check("enc_start_off", 32'(eng_start), 32'd0);
    wait_done(20, td);
    check("enc_lat", 32'(td - tg), 32'd10);
    check("enc_res", 32'(enc_result), 32'b101);
    check("enc_err", 32'(err_timeout), 32'd0);
    check("enc_done_only", 32'(dec_done), 32'd0);
`ifdef TURBO_SCHED_STATS_EN
    check("stat_enc", 32'(stat_enc_cnt), 32'd1);
`else
    check("stat_enc", 32'(stat_enc_cnt), 32'd0);
`endif
    tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("mode_hold", 32'(eng_mode), 32'd1);

    // decode 3'b011
    dec_sym = 3'b011; dec_req = 1'b1;
    wait_gnt(who, tg);
    dec_req = 1'b0;
    check("dec_who", 32'(who), 32'd0);
    tick();
    check("dec_start", 32'(eng_start), 32'd1);
    check("dec_sym", 32'(eng_sym), 32'b011);
    check("dec_mode", 32'(eng_mode), 32'd0);
    tick();
    check("dec_start_off", 32'(eng_start), 32'd0);
    wait_done(20, td);
    check("dec_lat", 32'(td - tg), 32'd3);
    check("dec_res", 32'(dec_result), 32'd1);
    check("dec_err", 32'(err_timeout), 32'd0);
    check("enc_res_held", 32'(enc_result), 32'b101);

    // both held after reset: enc, dec, enc, dec with one idle cycle between done and gnt
    reset = 1'b1; tick(); reset = 1'b0;
    enc_data = 8'h0F; dec_sym = 3'b110;
    enc_req = 1'b1; dec_req = 1'b1;
    td = 0;
    for (int k = 0; k < 4; k++) begin
      tprev = td;
      wait_gnt(who, tg);
      check("alt_who", 32'(who), (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k > 0) check("alt_gap", 32'(tg - tprev), 32'd2);
      if (k == 3) begin enc_req = 1'b0; dec_req = 1'b0; end
      wait_done(30, td);
    end
    tick();

    // engine never answers: decode times out 64 cycles after WAIT entry
    model_en = 1'b0;
    dec_sym = 3'b001; dec_req = 1'b1;
    wait_gnt(who, tg);
    dec_req = 1'b0;
    wait_done(100, td);
    check("to_lat", 32'(td - (tg + 2)), 32'd64);
    check("to_err", 32'(err_timeout), 32'd1);
    check("to_res", 32'(dec_result), 32'd0);
`ifdef TURBO_SCHED_STATS_EN
    check("stat_to", 32'(stat_to_cnt), 32'd1);
`else
    check("stat_to", 32'(stat_to_cnt), 32'd0);
`endif
    tick();
    check("to_err_pulse", 32'(err_timeout), 32'd0);
    model_en = 1'b1;

    // valid forced during FEED with a wrong result must be ignored
    enc_data = 8'h3C; enc_req = 1'b1;
    wait_gnt(who, tg);
    enc_req = 1'b0;
    force_enc_out = 3'b010; force_valid = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (enc_done) saw = 1'b1;
    end
    force_valid = 1'b0;
    check("stale_no_done", 32'(saw), 32'd0);
    wait_done(20, td);
    check("stale_lat", 32'(td - tg), 32'd10);
    check("stale_res", 32'(enc_result), 32'b101);
    tick();

    // reset in the 4th FEED cycle aborts the encode
    enc_data = 8'hFF; enc_req = 1'b1;
    wait_gnt(who, tg);
    enc_req = 1'b0;
    repeat (4) tick();
    check("abort_feed", 32'(eng_start), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_start", 32'(eng_start), 32'd0);
    check("abort_mode", 32'(eng_mode), 32'd0);
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (enc_done || dec_done) saw = 1'b1;
    end
    check("abort_no_done", 32'(saw), 32'd0);
    enc_data = 8'hA5; enc_req = 1'b1;
    wait_gnt(who, tg);
    enc_req = 1'b0;
    check("post_abort_who", 32'(who), 32'd1);
    wait_done(20, td);
    check("post_abort_lat", 32'(td - tg), 32'd10);
    check("post_abort_res", 32'(enc_result), 32'b101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
